ex_stage_pipe: RTL and testbench
================================

EX_STAGE_PIPE -- requirements
Module: ex_stage_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 32, datapath width.
REQ-002 SHALL have parameter REG_W, default 5, register-index width.
REQ-003 SHALL have port Clk, input, 1, single clock; all state on its rising edge.
REQ-004 SHALL have port Reset, input, 1, synchronous, active-high.
REQ-005 SHALL have ports in_valid (input, 1) and in_ready (output, 1), the ID/EX handshake.
REQ-006 SHALL have input ports alu_op (4, package enum), rs_data (DATA_W), rt_data (DATA_W), imm (DATA_W, sign-extended) and pc_plus4 (DATA_W).
REQ-007 SHALL have input ports rt and rd (REG_W each), plus 1-bit inputs reg_dst, alu_src, reg_write, mem_to_reg, mem_read, mem_write and branch.
REQ-008 SHALL have input port flush (1), which kills the held result and any in-progress multiply.
REQ-009 SHALL have ports out_valid (output, 1) and out_ready (input, 1), the EX/MEM handshake.
REQ-010 SHALL have registered outputs alu_result (DATA_W), zero (1), branch_target (DATA_W), store_data (DATA_W), dest_reg (REG_W), and out_reg_write, out_mem_to_reg, out_mem_read, out_mem_write, out_branch (1 each).
REQ-011 SHALL have output busy (1), high while a multiply iterates.

Function
REQ-012 SHALL accept an op when in_valid && in_ready.
REQ-013 SHALL drive in_ready = (state==IDLE) && (!out_valid || out_ready).
REQ-014 SHALL select operand B as imm when alu_src=1, else rt_data.
REQ-015 SHALL compute branch_target = pc_plus4 + (imm << 2), modulo 2^DATA_W.
REQ-016 SHALL set dest_reg to rd when reg_dst=1, else rt.
REQ-017 SHALL copy rt_data to store_data.
REQ-018 SHALL support single-cycle ops ADD, SUB, AND, OR, XOR, NOR, SLT (signed), SLTU, SLL, SRL and SRA, with shift amount B[4:0]; each SHALL register its result one cycle after acceptance.
REQ-019 SHALL set zero=1 iff the registered alu_result equals 0.
REQ-020 SHALL implement MULT and MULTU as iterative shift-add multiplies producing a 2*DATA_W product in HI:LO.
REQ-021 SHALL complete a multiply in exactly DATA_W cycles after acceptance, handling signed operands by magnitude with sign correction.
REQ-022 SHALL return HI for MFHI and LO for MFLO as single-cycle ops.
REQ-023 SHALL use FSM states IDLE and MUL.
REQ-024 SHALL transition IDLE->MUL on accepting MULT/MULTU, and MUL->IDLE when the iteration counter reaches DATA_W-1, writing HI/LO on that same edge.
REQ-025 SHALL produce a MULT/MULTU output beat on completion with out_reg_write=0, alu_result=LO and out_valid=1.
REQ-026 SHALL hold every output stable while out_valid && !out_ready.
REQ-027 SHALL clear out_valid on an out_valid && out_ready edge unless a new op is accepted on that edge.
REQ-028 SHALL, on flush, clear out_valid, force state to IDLE and leave HI/LO unchanged; flush SHALL take priority over acceptance in the same cycle.
REQ-029 SHALL keep in_ready=0 during MUL, so an MFHI/MFLO arriving then waits.

Reset
REQ-030 SHALL, on Reset, set state=IDLE, the counter to 0, HI=LO=0, out_valid=0, every data output to 0 and every control output to 0.
REQ-031 SHALL let Reset abort an in-progress multiply with no later output beat.

Structure
REQ-032 SHALL take the alu_op enum and the FSM state encoding from the shared package ex_pkg.
REQ-033 SHALL place the iterative multiplier in one sub-module, mul_iter, with start/done, signed select and a 2*DATA_W product.

Verification
REQ-034 SHALL cover ADD with rs=5, rt=7, alu_src=0 -> alu_result=12, zero=0 and out_valid one cycle after acceptance.
REQ-035 SHALL cover SUB with rs=9, imm=9, alu_src=1 and branch=1, pc_plus4=0x100 -> zero=1 and branch_target=0x124.
REQ-036 SHALL cover MULT with rs=-3, rt=4 -> busy for 32 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFF4, and a later MFLO returns 0xFFFFFFF4.
REQ-037 SHALL cover out_ready held low for 3 cycles with out_valid=1 -> outputs stable and in_ready=0 throughout.
REQ-038 SHALL cover flush at cycle 10 of a MULTU -> state IDLE, no output beat and HI/LO unchanged.
REQ-039 SHALL cover Reset asserted mid-multiply -> all outputs 0 on the next cycle and in_ready=1 the cycle after Reset deasserts.

Source files
------------

// File: rtl/ex_pkg.sv
// rtl/ex_pkg.sv - shared ALU opcode and EX-stage FSM state encodings
package ex_pkg;

   typedef enum logic [3:0] {
      OP_ADD   = 4'd0,
      OP_SUB   = 4'd1,
      OP_AND   = 4'd2,
      OP_OR    = 4'd3,
      OP_XOR   = 4'd4,
      OP_NOR   = 4'd5,
      OP_SLT   = 4'd6,
      OP_SLTU  = 4'd7,
      OP_SLL   = 4'd8,
      OP_SRL   = 4'd9,
      OP_SRA   = 4'd10,
      OP_MULT  = 4'd11,
      OP_MULTU = 4'd12,
      OP_MFHI  = 4'd13,
      OP_MFLO  = 4'd14
   } aluOp_e;

   typedef enum logic {
      IDLE = 1'b0,
      MUL  = 1'b1
   } exState_e;

endpackage

// File: rtl/mul_iter.sv
// rtl/mul_iter.sv - iterative shift-add multiplier, one multiplier bit per cycle
module mul_iter #(
   parameter int DATA_W = 32
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic                  start,
   input  logic                  abort,
   input  logic                  signedOp,
   input  logic [DATA_W-1:0]     opA,
   input  logic [DATA_W-1:0]     opB,
   output logic                  done,
   output logic [2*DATA_W-1:0]   product
);
   localparam int CNT_W = $clog2(DATA_W);

   logic                running;
   logic                negate;
   logic [CNT_W-1:0]    count;
   logic [DATA_W-1:0]   mcand;
   logic [2*DATA_W-1:0] acc;
   logic [DATA_W:0]     sum;
   logic [2*DATA_W-1:0] accNext;
   logic [DATA_W-1:0]   magA;
   logic [DATA_W-1:0]   magB;

   // Signed operands are multiplied as magnitudes; the sign is reapplied on the final step.
   always_comb begin
      magA    = (signedOp && opA[DATA_W-1]) ? -opA : opA;
      magB    = (signedOp && opB[DATA_W-1]) ? -opB : opB;
      sum     = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, mcand} : '0);
      accNext = {sum, acc[DATA_W-1:1]};
      done    = running && (count == CNT_W'(DATA_W - 1));
      product = negate ? -accNext : accNext;
   end

   always_ff @(posedge Clk) begin
      if (Reset || abort) begin
         running <= 1'b0;
         negate  <= 1'b0;
         count   <= '0;
         mcand   <= '0;
         acc     <= '0;
      end else if (start) begin
         running <= 1'b1;
         negate  <= signedOp && (opA[DATA_W-1] ^ opB[DATA_W-1]);
         count   <= '0;
         mcand   <= magA;
         acc     <= {{DATA_W{1'b0}}, magB};
      end else if (running) begin
         acc   <= accNext;
         count <= count + 1'b1;
         if (done) running <= 1'b0;
      end
   end

endmodule

// File: rtl/ex_stage_pipe.sv
// rtl/ex_stage_pipe.sv - EX pipeline stage: ALU, branch target, iterative HI/LO multiply
module ex_stage_pipe
   import ex_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  aluOp_e            alu_op,
   input  logic [DATA_W-1:0] rs_data,
   input  logic [DATA_W-1:0] rt_data,
   input  logic [DATA_W-1:0] imm,
   input  logic [DATA_W-1:0] pc_plus4,
   input  logic [REG_W-1:0]  rt,
   input  logic [REG_W-1:0]  rd,
   input  logic              reg_dst,
   input  logic              alu_src,
   input  logic              reg_write,
   input  logic              mem_to_reg,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic              branch,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] alu_result,
   output logic              zero,
   output logic [DATA_W-1:0] branch_target,
   output logic [DATA_W-1:0] store_data,
   output logic [REG_W-1:0]  dest_reg,
   output logic              out_reg_write,
   output logic              out_mem_to_reg,
   output logic              out_mem_read,
   output logic              out_mem_write,
   output logic              out_branch,
   output logic              busy
);
   exState_e            state;
   exState_e            nextState;
   logic [DATA_W-1:0]   hiReg;
   logic [DATA_W-1:0]   loReg;
   logic [DATA_W-1:0]   opB;
   logic [DATA_W-1:0]   aluOut;
   logic [2*DATA_W-1:0] mulProduct;
   logic                mulDone;
   logic                isMul;
   logic                accept;

   assign in_ready = (state == IDLE) && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;
   assign isMul    = (alu_op == OP_MULT) || (alu_op == OP_MULTU);
   assign opB      = alu_src ? imm : rt_data;
   assign busy     = (state == MUL);

   mul_iter #(.DATA_W(DATA_W)) uMul (
      .Clk      (Clk),
      .Reset    (Reset),
      .start    (accept && isMul && !flush),
      .abort    (flush),
      .signedOp (alu_op == OP_MULT),
      .opA      (rs_data),
      .opB      (rt_data),
      .done     (mulDone),
      .product  (mulProduct)
   );

   always_comb begin
      aluOut = '0;
      case (alu_op)
         OP_ADD:  aluOut = rs_data + opB;
         OP_SUB:  aluOut = rs_data - opB;
         OP_AND:  aluOut = rs_data & opB;
         OP_OR:   aluOut = rs_data | opB;
         OP_XOR:  aluOut = rs_data ^ opB;
         OP_NOR:  aluOut = ~(rs_data | opB);
         OP_SLT:  aluOut = {{(DATA_W-1){1'b0}}, ($signed(rs_data) < $signed(opB))};
         OP_SLTU: aluOut = {{(DATA_W-1){1'b0}}, (rs_data < opB)};
         OP_SLL:  aluOut = rs_data << opB[4:0];
         OP_SRL:  aluOut = rs_data >> opB[4:0];
         OP_SRA:  aluOut = $signed(rs_data) >>> opB[4:0];
         OP_MFHI: aluOut = hiReg;
         OP_MFLO: aluOut = loReg;
         default: aluOut = '0;
      endcase
   end

   always_comb begin
      nextState = state;
      case (state)
         IDLE:    if (accept && isMul) nextState = MUL;
         MUL:     if (mulDone) nextState = IDLE;
         default: nextState = IDLE;
      endcase
      if (flush) nextState = IDLE;
   end

   // Multiply acceptance loads the side fields now; the beat itself is raised on completion.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state          <= IDLE;
         hiReg          <= '0;
         loReg          <= '0;
         out_valid      <= 1'b0;
         alu_result     <= '0;
         zero           <= 1'b0;
         branch_target  <= '0;
         store_data     <= '0;
         dest_reg       <= '0;
         out_reg_write  <= 1'b0;
         out_mem_to_reg <= 1'b0;
         out_mem_read   <= 1'b0;
         out_mem_write  <= 1'b0;
         out_branch     <= 1'b0;
      end else begin
         state <= nextState;
         if (flush) begin
            out_valid <= 1'b0;
         end else if (mulDone) begin
            hiReg      <= mulProduct[2*DATA_W-1:DATA_W];
            loReg      <= mulProduct[DATA_W-1:0];
            alu_result <= mulProduct[DATA_W-1:0];
            zero       <= (mulProduct[DATA_W-1:0] == '0);
            out_valid  <= 1'b1;
         end else if (accept) begin
            out_valid      <= !isMul;
            alu_result     <= aluOut;
            zero           <= (aluOut == '0);
            branch_target  <= pc_plus4 + (imm << 2);
            store_data     <= rt_data;
            dest_reg       <= reg_dst ? rd : rt;
            out_reg_write  <= reg_write && !isMul;
            out_mem_to_reg <= mem_to_reg;
            out_mem_read   <= mem_read;
            out_mem_write  <= mem_write;
            out_branch     <= branch;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ex_stage_pipe.sv
// tb/tb_ex_stage_pipe.sv - directed scoreboard bench for ex_stage_pipe
module tb_ex_stage_pipe;
   import ex_pkg::*;

   typedef struct {
      logic [31:0] res;
      logic        z;
      logic [31:0] bt;
      logic [4:0]  dst;
      logic        rw;
   } expBeat_t;

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   aluOp_e      alu_op = OP_ADD;
   logic [31:0] rs_data = '0, rt_data = '0, imm = '0, pc_plus4 = '0;
   logic [4:0]  rt = 5'd2, rd = 5'd3;
   logic        reg_dst = 1'b0, alu_src = 1'b0, reg_write = 1'b1;
   logic        mem_to_reg = 1'b0, mem_read = 1'b0, mem_write = 1'b0, branch = 1'b0;
   logic        flush = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] alu_result, branch_target, store_data;
   logic        zero;
   logic [4:0]  dest_reg;
   logic        out_reg_write, out_mem_to_reg, out_mem_read, out_mem_write, out_branch;
   logic        busy;

   int total = 0;
   int bad = 0;
   expBeat_t sbQ[$];

   always #5 Clk = ~Clk;

   ex_stage_pipe #(.DATA_W(32), .REG_W(5)) dut (
      .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready),
      .alu_op(alu_op), .rs_data(rs_data), .rt_data(rt_data), .imm(imm), .pc_plus4(pc_plus4),
      .rt(rt), .rd(rd), .reg_dst(reg_dst), .alu_src(alu_src), .reg_write(reg_write),
      .mem_to_reg(mem_to_reg), .mem_read(mem_read), .mem_write(mem_write), .branch(branch),
      .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
      .alu_result(alu_result), .zero(zero), .branch_target(branch_target),
      .store_data(store_data), .dest_reg(dest_reg), .out_reg_write(out_reg_write),
      .out_mem_to_reg(out_mem_to_reg), .out_mem_read(out_mem_read),
      .out_mem_write(out_mem_write), .out_branch(out_branch), .busy(busy)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic sendOp(input aluOp_e op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] im, input logic src, input logic [31:0] pc,
                         input logic rdst, input logic [31:0] expRes, input logic expRw,
                         input logic push);
      int n = 0;
      expBeat_t e;
      alu_op = op; rs_data = a; rt_data = b; imm = im; alu_src = src;
      pc_plus4 = pc; reg_dst = rdst; in_valid = 1'b1;
      if (push) begin
         e.res = expRes; e.z = (expRes == 32'd0); e.bt = pc + (im << 2);
         e.dst = rdst ? 5'd3 : 5'd2; e.rw = expRw;
         sbQ.push_back(e);
      end
      while (!in_ready && n < 100) begin @(negedge Clk); n++; end
      check("send_ready", in_ready, 1);
      @(posedge Clk);
      @(negedge Clk);
      in_valid = 1'b0;
   endtask

   task automatic checkBeat(input string tag);
      int n = 0;
      expBeat_t e;
      while (!out_valid && n < 64) begin @(negedge Clk); n++; end
      check({tag, "_valid"}, out_valid, 1);
      check({tag, "_sb"}, sbQ.size() != 0, 1);
      if (out_valid && sbQ.size() != 0) begin
         e = sbQ.pop_front();
         check({tag, "_res"}, alu_result, e.res);
         check({tag, "_zero"}, zero, e.z);
         check({tag, "_bt"}, branch_target, e.bt);
         check({tag, "_dst"}, dest_reg, e.dst);
         check({tag, "_rw"}, out_reg_write, e.rw);
      end
      @(negedge Clk);
   endtask

   initial begin
      aluOp_e      ops  [11];
      logic [31:0] exps [11];
      int          cnt;

      ops  = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT, OP_SLTU, OP_SLL, OP_SRL, OP_SRA};
      exps = '{32'h800001F4, 32'h7FFFFFEC, 32'h00000000, 32'h800001F4, 32'h800001F4,
               32'h7FFFFE0B, 32'h00000001, 32'h00000000, 32'h00000F00, 32'h0800000F, 32'hF800000F};

      repeat (3) @(negedge Clk);
      check("rst_valid", out_valid, 0);
      check("rst_res", alu_result, 0);
      check("rst_busy", busy, 0);
      check("rst_ready", in_ready, 1);
      check("rst_regwrite", out_reg_write, 0);
      Reset = 1'b0;
      @(negedge Clk);

      sendOp(OP_ADD, 32'd5, 32'd7, 32'd0, 1'b0, 32'd0, 1'b1, 32'd12, 1'b1, 1'b1);
      check("add_valid_1cyc", out_valid, 1);
      checkBeat("add");

      branch = 1'b1;
      sendOp(OP_SUB, 32'd9, 32'd1, 32'd9, 1'b1, 32'h100, 1'b0, 32'd0, 1'b1, 1'b1);
      check("sub_bt", branch_target, 32'h124);
      check("sub_branch", out_branch, 1);
      check("sub_zero", zero, 1);
      checkBeat("sub");
      branch = 1'b0;

      for (int i = 0; i < 11; i++) begin
         sendOp(ops[i], 32'h800000F0, 32'h00000104, 32'h0, 1'b0, 32'h40, i[0], exps[i], 1'b1, 1'b1);
         checkBeat("alu_tbl");
      end

      sendOp(OP_MULT, 32'hFFFFFFFD, 32'd4, 32'd0, 1'b0, 32'd0, 1'b0, 32'hFFFFFFF4, 1'b0, 1'b1);
      cnt = 0;
      while (busy && cnt < 100) begin
         if (cnt == 5) check("mul_ready_low", in_ready, 0);
         cnt++;
         @(negedge Clk);
      end
      check("mul_busy_cycles", cnt, 32);
      checkBeat("mult");
      sendOp(OP_MFHI, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b1);
      checkBeat("mfhi");
      sendOp(OP_MFLO, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b1, 32'hFFFFFFF4, 1'b1, 1'b1);
      checkBeat("mflo");

      out_ready = 1'b0;
      sendOp(OP_ADD, 32'd1, 32'd2, 32'd0, 1'b0, 32'd0, 1'b1, 32'd3, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) begin
         check("bp_valid", out_valid, 1);
         check("bp_res", alu_result, 32'd3);
         check("bp_dst", dest_reg, 5'd3);
         check("bp_ready", in_ready, 0);
         @(negedge Clk);
      end
      out_ready = 1'b1;
      checkBeat("bp");

      sendOp(OP_MULTU, 32'd5, 32'd6, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
      repeat (9) @(negedge Clk);
      flush = 1'b1;
      @(negedge Clk);
      flush = 1'b0;
      check("flush_busy", busy, 0);
      check("flush_valid", out_valid, 0);
      check("flush_ready", in_ready, 1);
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         if (out_valid) cnt++;
         @(negedge Clk);
      end
      check("flush_no_beat", cnt, 0);
      sendOp(OP_MFHI, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b1);
      checkBeat("flush_hi");
      sendOp(OP_MFLO, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b1, 32'hFFFFFFF4, 1'b1, 1'b1);
      checkBeat("flush_lo");

      sendOp(OP_MULT, 32'd7, 32'd7, 32'd0, 1'b0, 32'h80, 1'b1, 32'd0, 1'b0, 1'b0);
      repeat (5) @(negedge Clk);
      Reset = 1'b1;
      @(negedge Clk);
      check("rstmid_valid", out_valid, 0);
      check("rstmid_busy", busy, 0);
      check("rstmid_res", alu_result, 0);
      check("rstmid_bt", branch_target, 0);
      check("rstmid_dst", dest_reg, 0);
      Reset = 1'b0;
      @(negedge Clk);
      check("rstmid_ready", in_ready, 1);
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         if (out_valid) cnt++;
         @(negedge Clk);
      end
      check("rstmid_no_beat", cnt, 0);
      sendOp(OP_MFLO, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b1);
      checkBeat("rstmid_lo");

      check("sb_empty", sbQ.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
